hv_encoder_mb: RTL and testbench

Multi-bundler hypervector encoder: the next-generation encoder datapath, generalised to `NumBund` bundlers, `RegNum` HV registers and a `QFifoDepth`-deep query-HV output FIFO with a valid/ready handshake. It sits between the item memories and the associative memory. A central controller drives its mux selects and enables every cycle. All bundler counters, the register file and the FIFO live inside this block; the ALU is the existing combinational `hv_alu_pe`.

---
 rtl/hv_encoder_mb.sv | 277 +++++++++++++++++++++++++++
 tb/tb_hv_encoder_mb.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_encoder_mb.sv
// hv_encoder_mb: multi-bundler hypervector encoder datapath.
// Bundlers, HV register file, ALU and query-HV output FIFO.
//
// Ports:
//   clk_i, rst_i (sync, active-high), global_stall_i
//   im_rd_a_i, im_rd_b_i           item memory HVs
//   alu_mux_a_i, alu_mux_b_i       ALU operand selects
//   alu_ops_i, alu_shift_amt_i     ALU operation / shift amount
//   bund_mux_i, bund_valid_i,      per-bundler input select,
//   bund_clr_i                     accumulate enable, clear
//   reg_mux_i, reg_rd_addr_a_i,    register file write-data select,
//   reg_rd_addr_b_i, reg_wr_addr_i read/write addresses,
//   reg_wr_en_i                    write enable
//   qhv_mux_i, qhv_wen_i,          query source select, push,
//   qhv_clr_i, qhv_ready_i         flush, consumer ready
//   qhv_valid_o, qhv_o,            FIFO non-empty, FIFO head,
//   qhv_stall_o, qhv_count_o       FIFO full, occupancy

// hv_alu_pe: combinational HV ALU.
// Ops: 0 xor, 1 and, 2 or, 3 rotate A left, 4 rotate A right,
// 5 pass A, 6 pass B, 7 not A.
module hv_alu_pe #(
   parameter int HVDimension    = 512,
   parameter int NumALUOps      = 8,
   parameter int ALUMaxShiftAmt = 128,
   localparam int OpWidth    = $clog2(NumALUOps),
   localparam int ShiftWidth = $clog2(ALUMaxShiftAmt)
) (
   input  logic [HVDimension-1:0] a_i,
   input  logic [HVDimension-1:0] b_i,
   input  logic [OpWidth-1:0]     op_i,
   input  logic [ShiftWidth-1:0]  shift_amt_i,
   output logic [HVDimension-1:0] c_o
);

   int sh;
   int sh_inv;

   always_comb begin
      sh     = int'(shift_amt_i);
      sh_inv = HVDimension - sh;
      c_o    = '0;
      case (op_i)
         OpWidth'(0): c_o = a_i ^ b_i;
         OpWidth'(1): c_o = a_i & b_i;
         OpWidth'(2): c_o = a_i | b_i;
         OpWidth'(3): c_o = (a_i << sh) | (a_i >> sh_inv);
         OpWidth'(4): c_o = (a_i >> sh) | (a_i << sh_inv);
         OpWidth'(5): c_o = a_i;
         OpWidth'(6): c_o = b_i;
         OpWidth'(7): c_o = ~a_i;
         default:     c_o = '0;
      endcase
   end

endmodule

module hv_encoder_mb #(
   parameter int HVDimension    = 512,
   parameter int NumBund        = 4,
   parameter int BundCountWidth = 8,
   parameter int RegNum         = 4,
   parameter int QFifoDepth     = 4,
   parameter int NumALUOps      = 8,
   parameter int ALUMaxShiftAmt = 128,
   localparam int SrcSelWidth  = $clog2(NumBund + 2),
   localparam int RegAddrWidth = $clog2(RegNum),
   localparam int OpWidth      = $clog2(NumALUOps),
   localparam int ShiftWidth   = $clog2(ALUMaxShiftAmt),
   localparam int CountWidth   = $clog2(QFifoDepth + 1)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      global_stall_i,
   input  logic [HVDimension-1:0]    im_rd_a_i,
   input  logic [HVDimension-1:0]    im_rd_b_i,
   input  logic [SrcSelWidth-1:0]    alu_mux_a_i,
   input  logic [SrcSelWidth-1:0]    alu_mux_b_i,
   input  logic [OpWidth-1:0]        alu_ops_i,
   input  logic [ShiftWidth-1:0]     alu_shift_amt_i,
   input  logic [2*NumBund-1:0]      bund_mux_i,
   input  logic [NumBund-1:0]        bund_valid_i,
   input  logic [NumBund-1:0]        bund_clr_i,
   input  logic [SrcSelWidth-1:0]    reg_mux_i,
   input  logic [RegAddrWidth-1:0]   reg_rd_addr_a_i,
   input  logic [RegAddrWidth-1:0]   reg_rd_addr_b_i,
   input  logic [RegAddrWidth-1:0]   reg_wr_addr_i,
   input  logic                      reg_wr_en_i,
   input  logic [SrcSelWidth-1:0]    qhv_mux_i,
   input  logic                      qhv_wen_i,
   input  logic                      qhv_clr_i,
   input  logic                      qhv_ready_i,
   output logic                      qhv_valid_o,
   output logic [HVDimension-1:0]    qhv_o,
   output logic                      qhv_stall_o,
   output logic [CountWidth-1:0]     qhv_count_o
);

   typedef logic [HVDimension-1:0] hv_t;
   typedef logic [NumBund-1:0][HVDimension-1:0] bund_hv_t;

   localparam int PtrWidth =
      (QFifoDepth > 1) ? $clog2(QFifoDepth) : 1;
   localparam logic [PtrWidth-1:0] PtrLast =
      PtrWidth'(QFifoDepth - 1);
   localparam logic [CountWidth-1:0] CountFull =
      CountWidth'(QFifoDepth);

   // Shared source decode: 0/1 pick the two fixed sources,
   // 2+k picks bundler k, anything else yields zeros.
   function automatic hv_t src_pick(
      input logic [SrcSelWidth-1:0] sel,
      input hv_t                    s0,
      input hv_t                    s1,
      input bund_hv_t               bo
   );
      hv_t r;
      r = '0;
      for (int k = 0; k < NumBund; k++) begin
         if (int'(sel) == k + 2) r = bo[k];
      end
      if (int'(sel) == 0) r = s0;
      if (int'(sel) == 1) r = s1;
      return r;
   endfunction

   function automatic logic [PtrWidth-1:0] ptr_inc(
      input logic [PtrWidth-1:0] p
   );
      return (p == PtrLast) ? '0 : p + PtrWidth'(1);
   endfunction

   hv_t      reg_q [RegNum];
   hv_t      reg_a;
   hv_t      reg_b;
   hv_t      alu_a;
   hv_t      alu_b;
   hv_t      alu_c;
   hv_t      reg_wdata;
   hv_t      qhv_wdata;
   bund_hv_t bund_out;

   assign reg_a = reg_q[reg_rd_addr_a_i];
   assign reg_b = reg_q[reg_rd_addr_b_i];

   assign alu_a = src_pick(alu_mux_a_i, im_rd_a_i, reg_a, bund_out);
   assign alu_b = src_pick(alu_mux_b_i, im_rd_b_i, reg_b, bund_out);

   hv_alu_pe #(
      .HVDimension    (HVDimension),
      .NumALUOps      (NumALUOps),
      .ALUMaxShiftAmt (ALUMaxShiftAmt)
   ) u_alu (
      .a_i         (alu_a),
      .b_i         (alu_b),
      .op_i        (alu_ops_i),
      .shift_amt_i (alu_shift_amt_i),
      .c_o         (alu_c)
   );

   assign reg_wdata = src_pick(reg_mux_i, alu_c, im_rd_a_i, bund_out);
   assign qhv_wdata = src_pick(qhv_mux_i, alu_c, reg_a, bund_out);

   // Bundlers
   localparam logic signed [BundCountWidth-1:0] CMax =
      {1'b0, {(BundCountWidth-1){1'b1}}};
   localparam logic signed [BundCountWidth-1:0] CMin =
      {1'b1, {(BundCountWidth-1){1'b0}}};
   localparam logic signed [BundCountWidth-1:0] COne =
      BundCountWidth'(1);
   localparam logic signed [BundCountWidth-1:0] CNeg = '1;
   localparam logic signed [BundCountWidth-1:0] CZero = '0;

   for (genvar k = 0; k < NumBund; k++) begin : g_bund
      localparam int Nxt = (k + 1) % NumBund;

      logic signed [BundCountWidth-1:0] cnt_q [HVDimension];
      logic [1:0] sel;
      logic       acc;
      logic       clr;
      hv_t        din;
      hv_t        bout;

      assign sel = bund_mux_i[2*k +: 2];
      assign acc = bund_valid_i[k] && !global_stall_i;
      assign clr = bund_clr_i[k];

      always_comb begin
         din = '0;
         unique case (sel)
            2'd0: din = alu_c;
            2'd1: din = bund_out[Nxt];
            2'd2: din = im_rd_a_i;
            2'd3: din = reg_a;
         endcase
      end

      // Clear with a same-cycle sample restarts at +/-1 so the
      // first vote of a new window is not lost.
      always_ff @(posedge clk_i) begin
         for (int i = 0; i < HVDimension; i++) begin
            if (rst_i) begin
               cnt_q[i] <= CZero;
            end else if (clr) begin
               cnt_q[i] <= acc ? (din[i] ? COne : CNeg) : CZero;
            end else if (acc) begin
               if (din[i] && cnt_q[i] != CMax)
                  cnt_q[i] <= cnt_q[i] + COne;
               else if (!din[i] && cnt_q[i] != CMin)
                  cnt_q[i] <= cnt_q[i] - COne;
            end
         end
      end

      always_comb begin
         bout = '0;
         for (int i = 0; i < HVDimension; i++)
            bout[i] = (cnt_q[i] > CZero);
      end

      assign bund_out[k] = bout;
   end

   // Register file: write-after-stall, no read bypass.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int r = 0; r < RegNum; r++) reg_q[r] <= '0;
      end else if (reg_wr_en_i && !global_stall_i) begin
         reg_q[reg_wr_addr_i] <= reg_wdata;
      end
   end

   // Query-HV FIFO
   hv_t                   fifo_q [QFifoDepth];
   logic [PtrWidth-1:0]   rd_ptr_q;
   logic [PtrWidth-1:0]   wr_ptr_q;
   logic [CountWidth-1:0] count_q;
   logic                  fifo_full;
   logic                  q_pop;
   logic                  q_push;

   assign fifo_full   = (count_q == CountFull);
   assign qhv_valid_o = (count_q != '0);
   // Pop ignores the global stall so the consumer never deadlocks.
   assign q_pop  = qhv_valid_o && qhv_ready_i;
   assign q_push = qhv_wen_i && !global_stall_i &&
                   (!fifo_full || q_pop);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int e = 0; e < QFifoDepth; e++) fifo_q[e] <= '0;
      end else if (qhv_clr_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (q_push) begin
            fifo_q[wr_ptr_q] <= qhv_wdata;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (q_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (q_push && !q_pop)
            count_q <= count_q + CountWidth'(1);
         else if (q_pop && !q_push)
            count_q <= count_q - CountWidth'(1);
      end
   end

   // Masked so a flushed FIFO does not expose stale entries.
   assign qhv_o       = qhv_valid_o ? fifo_q[rd_ptr_q] : '0;
   assign qhv_stall_o = fifo_full;
   assign qhv_count_o = count_q;

endmodule

// File: tb/tb_hv_encoder_mb.sv
// tb_hv_encoder_mb: directed scenarios plus random traffic
// checked against a behavioural model of the encoder.
module tb_hv_encoder_mb;

   localparam int D  = 512;
   localparam int NB = 4;
   localparam int W  = 8;
   localparam int RN = 4;
   localparam int QD = 4;
   localparam int CMAX = (1 << (W - 1)) - 1;
   localparam int CMIN = -(1 << (W - 1));

   typedef logic [D-1:0] hv_t;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          global_stall_i;
   hv_t           im_rd_a_i;
   hv_t           im_rd_b_i;
   logic [2:0]    alu_mux_a_i;
   logic [2:0]    alu_mux_b_i;
   logic [2:0]    alu_ops_i;
   logic [6:0]    alu_shift_amt_i;
   logic [2*NB-1:0] bund_mux_i;
   logic [NB-1:0] bund_valid_i;
   logic [NB-1:0] bund_clr_i;
   logic [2:0]    reg_mux_i;
   logic [1:0]    reg_rd_addr_a_i;
   logic [1:0]    reg_rd_addr_b_i;
   logic [1:0]    reg_wr_addr_i;
   logic          reg_wr_en_i;
   logic [2:0]    qhv_mux_i;
   logic          qhv_wen_i;
   logic          qhv_clr_i;
   logic          qhv_ready_i;
   logic          qhv_valid_o;
   hv_t           qhv_o;
   logic          qhv_stall_o;
   logic [2:0]    qhv_count_o;

   int checks   = 0;
   int failures = 0;

   // Model state
   int  mcnt [NB][D];
   hv_t mreg [RN];
   hv_t mq [$];

   always #5 clk_i = ~clk_i;

   hv_encoder_mb dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .global_stall_i  (global_stall_i),
      .im_rd_a_i       (im_rd_a_i),
      .im_rd_b_i       (im_rd_b_i),
      .alu_mux_a_i     (alu_mux_a_i),
      .alu_mux_b_i     (alu_mux_b_i),
      .alu_ops_i       (alu_ops_i),
      .alu_shift_amt_i (alu_shift_amt_i),
      .bund_mux_i      (bund_mux_i),
      .bund_valid_i    (bund_valid_i),
      .bund_clr_i      (bund_clr_i),
      .reg_mux_i       (reg_mux_i),
      .reg_rd_addr_a_i (reg_rd_addr_a_i),
      .reg_rd_addr_b_i (reg_rd_addr_b_i),
      .reg_wr_addr_i   (reg_wr_addr_i),
      .reg_wr_en_i     (reg_wr_en_i),
      .qhv_mux_i       (qhv_mux_i),
      .qhv_wen_i       (qhv_wen_i),
      .qhv_clr_i       (qhv_clr_i),
      .qhv_ready_i     (qhv_ready_i),
      .qhv_valid_o     (qhv_valid_o),
      .qhv_o           (qhv_o),
      .qhv_stall_o     (qhv_stall_o),
      .qhv_count_o     (qhv_count_o)
   );

   task automatic chk(input string tag, input hv_t got,
                      input hv_t exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic hv_t m_bout(int k);
      hv_t r = '0;
      for (int i = 0; i < D; i++) r[i] = (mcnt[k][i] > 0);
      return r;
   endfunction

   function automatic hv_t m_src(int sel, hv_t s0, hv_t s1);
      if (sel == 0) return s0;
      if (sel == 1) return s1;
      if (sel >= 2 && sel < NB + 2) return m_bout(sel - 2);
      return '0;
   endfunction

   function automatic hv_t m_alu(hv_t a, hv_t b, int op, int s);
      hv_t r = '0;
      case (op)
         0: r = a ^ b;
         1: r = a & b;
         2: r = a | b;
         3: for (int j = 0; j < D; j++) r[j] = a[(j - s + D) % D];
         4: for (int j = 0; j < D; j++) r[j] = a[(j + s) % D];
         5: r = a;
         6: r = b;
         7: r = ~a;
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic hv_t rnd_hv();
      hv_t v;
      int  m = $urandom_range(0, 7);
      for (int i = 0; i < D / 32; i++) v[i*32 +: 32] = $urandom;
      if (m == 0) v = '1;
      if (m == 1) v = '0;
      return v;
   endfunction

   // One clock: predict from current inputs, advance, compare.
   task automatic step();
      hv_t ra, rb, aa, ab, al, rw, qw, ex;
      hv_t bin [NB];
      bit  pop, push, vld, b;
      int  sz;
      ra = mreg[reg_rd_addr_a_i];
      rb = mreg[reg_rd_addr_b_i];
      aa = m_src(int'(alu_mux_a_i), im_rd_a_i, ra);
      ab = m_src(int'(alu_mux_b_i), im_rd_b_i, rb);
      al = m_alu(aa, ab, int'(alu_ops_i), int'(alu_shift_amt_i));
      for (int k = 0; k < NB; k++) begin
         case (bund_mux_i[2*k +: 2])
            2'd0: bin[k] = al;
            2'd1: bin[k] = m_bout((k + 1) % NB);
            2'd2: bin[k] = im_rd_a_i;
            default: bin[k] = ra;
         endcase
      end
      rw = m_src(int'(reg_mux_i), al, im_rd_a_i);
      qw = m_src(int'(qhv_mux_i), al, ra);
      sz = mq.size();
      pop  = (sz > 0) && qhv_ready_i;
      push = qhv_wen_i && !global_stall_i && (sz < QD || pop);
      @(posedge clk_i);
      if (rst_i) begin
         for (int k = 0; k < NB; k++)
            for (int i = 0; i < D; i++) mcnt[k][i] = 0;
         for (int r = 0; r < RN; r++) mreg[r] = '0;
         mq.delete();
      end else begin
         for (int k = 0; k < NB; k++) begin
            vld = bund_valid_i[k] && !global_stall_i;
            for (int i = 0; i < D; i++) begin
               b = bin[k][i];
               if (bund_clr_i[k])
                  mcnt[k][i] = vld ? (b ? 1 : -1) : 0;
               else if (vld) begin
                  mcnt[k][i] += b ? 1 : -1;
                  if (mcnt[k][i] > CMAX) mcnt[k][i] = CMAX;
                  if (mcnt[k][i] < CMIN) mcnt[k][i] = CMIN;
               end
            end
         end
         if (reg_wr_en_i && !global_stall_i) mreg[reg_wr_addr_i] = rw;
         if (qhv_clr_i) mq.delete();
         else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(qw);
         end
      end
      #1;
      sz = mq.size();
      ex = (sz > 0) ? mq[0] : '0;
      chk("m_valid", hv_t'(qhv_valid_o), hv_t'(sz > 0));
      chk("m_head", qhv_o, ex);
      chk("m_stall", hv_t'(qhv_stall_o), hv_t'(sz == QD));
      chk("m_count", hv_t'(qhv_count_o), hv_t'(sz));
   endtask

   task automatic idle();
      rst_i = 0; global_stall_i = 0;
      im_rd_a_i = '0; im_rd_b_i = '0;
      alu_mux_a_i = '0; alu_mux_b_i = '0;
      alu_ops_i = '0; alu_shift_amt_i = '0;
      bund_mux_i = '0; bund_valid_i = '0; bund_clr_i = '0;
      reg_mux_i = '0; reg_rd_addr_a_i = '0;
      reg_rd_addr_b_i = '0; reg_wr_addr_i = '0;
      reg_wr_en_i = 0; qhv_mux_i = '0;
      qhv_wen_i = 0; qhv_clr_i = 0; qhv_ready_i = 0;
   endtask

   // Route a source through the FIFO and compare the head.
   task automatic probe_src(input int sel, input int ra,
                            input hv_t exp, input string tag);
      idle(); qhv_clr_i = 1; step();
      idle(); qhv_wen_i = 1; qhv_mux_i = 3'(sel);
      reg_rd_addr_a_i = 2'(ra); step();
      chk(tag, qhv_o, exp);
      idle();
   endtask

   task automatic probe(input int k, input hv_t exp,
                        input string tag);
      probe_src(k + 2, 0, exp, tag);
   endtask

   task automatic bund_push(input int k, input int sel,
                            input hv_t data, input int n);
      idle();
      bund_mux_i[2*k +: 2] = 2'(sel);
      bund_valid_i[k] = 1;
      im_rd_a_i = data;
      repeat (n) step();
      idle();
   endtask

   hv_t v [5];
   hv_t pat;
   hv_t x;

   initial begin
      idle();
      rst_i = 1; step(); step();
      idle();
      chk("rst_valid", hv_t'(qhv_valid_o), '0);
      chk("rst_count", hv_t'(qhv_count_o), '0);
      chk("rst_stall", hv_t'(qhv_stall_o), '0);
      chk("rst_head", qhv_o, '0);

      // Majority
      bund_push(0, 2, '1, 3);
      bund_push(0, 2, '0, 1);
      probe(0, '1, "maj_p2");
      bund_push(0, 2, '0, 1);
      probe(0, '1, "maj_p1");
      bund_push(0, 2, '0, 2);
      probe(0, '0, "maj_m1");

      // Saturation and clear-with-valid
      idle(); bund_clr_i = 4'b0001; step();
      bund_push(0, 2, '1, 200);
      probe(0, '1, "sat_pos");
      bund_push(0, 2, '0, 126);
      probe(0, '1, "sat_127a");
      bund_push(0, 2, '0, 1);
      probe(0, '0, "sat_127b");
      bund_push(0, 2, '1, 5);
      idle(); bund_mux_i[1:0] = 2'd2; bund_valid_i = 4'b0001;
      bund_clr_i = 4'b0001; im_rd_a_i = '0; step();
      probe(0, '0, "clrv_a");
      bund_push(0, 2, '1, 1);
      probe(0, '0, "clrv_b");
      bund_push(0, 2, '1, 1);
      probe(0, '1, "clrv_c");

      // Chain: bundler 1 copies bundler 2
      pat = {(D / 8){8'hA5}};
      idle(); bund_clr_i = 4'b0110; step();
      bund_push(2, 2, pat, 1);
      probe(1, '0, "chain_pre");
      probe(2, pat, "chain_src");
      idle(); bund_mux_i[3:2] = 2'd1;
      bund_valid_i = 4'b0010; bund_clr_i = 4'b0010; step();
      probe(1, pat, "chain_dst");

      // FIFO fill, drop, ordered drain
      idle(); qhv_clr_i = 1; step();
      for (int i = 0; i < 5; i++) v[i] = rnd_hv() ^ hv_t'(i + 1);
      for (int i = 0; i < 5; i++) begin
         idle(); qhv_wen_i = 1; alu_ops_i = 3'd5;
         im_rd_a_i = v[i]; step();
         if (i == 3) chk("full_stall", hv_t'(qhv_stall_o), 1);
      end
      chk("drop_count", hv_t'(qhv_count_o), 4);
      idle(); qhv_ready_i = 1;
      for (int i = 0; i < 4; i++) begin
         chk("pop_order", qhv_o, v[i]);
         step();
         if (i == 0) chk("stall_rel", hv_t'(qhv_stall_o), 0);
      end
      chk("drain_valid", hv_t'(qhv_valid_o), 0);
      for (int i = 0; i < 4; i++) begin
         idle(); qhv_wen_i = 1; alu_ops_i = 3'd5;
         im_rd_a_i = v[i]; step();
      end
      idle(); qhv_wen_i = 1; qhv_ready_i = 1; alu_ops_i = 3'd5;
      im_rd_a_i = v[4]; step();
      chk("pp_count", hv_t'(qhv_count_o), 4);
      chk("pp_head", qhv_o, v[1]);

      // Global stall
      idle(); qhv_clr_i = 1; step();
      idle(); qhv_wen_i = 1; im_rd_a_i = v[0]; alu_ops_i = 3'd5;
      step();
      x = rnd_hv() | hv_t'(1);
      idle(); global_stall_i = 1; qhv_ready_i = 1;
      reg_wr_en_i = 1; reg_mux_i = 3'd1; im_rd_a_i = x;
      bund_valid_i = '1; bund_mux_i = 8'hAA; qhv_wen_i = 1;
      step();
      chk("stall_pop", hv_t'(qhv_count_o), 0);
      probe_src(1, 0, '0, "stall_reg");
      probe(3, '0, "stall_bund");
      idle(); reg_wr_en_i = 1; reg_mux_i = 3'd1; im_rd_a_i = x;
      step();
      probe_src(1, 0, x, "reg_write");

      // Reset mid-operation
      bund_push(3, 2, '1, 3);
      idle(); qhv_wen_i = 1; qhv_mux_i = 3'd5; step(); step();
      idle(); rst_i = 1; step();
      idle();
      chk("mrst_valid", hv_t'(qhv_valid_o), '0);
      chk("mrst_count", hv_t'(qhv_count_o), '0);
      chk("mrst_stall", hv_t'(qhv_stall_o), '0);
      chk("mrst_head", qhv_o, '0);
      probe(3, '0, "mrst_bund");

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         rst_i = ($urandom_range(0, 199) == 0);
         global_stall_i = ($urandom_range(0, 7) == 0);
         im_rd_a_i = rnd_hv();
         im_rd_b_i = rnd_hv();
         alu_mux_a_i = 3'($urandom);
         alu_mux_b_i = 3'($urandom);
         alu_ops_i = 3'($urandom);
         alu_shift_amt_i = 7'($urandom);
         bund_mux_i = 8'($urandom);
         bund_valid_i = 4'($urandom);
         for (int k = 0; k < NB; k++)
            bund_clr_i[k] = ($urandom_range(0, 15) == 0);
         reg_mux_i = 3'($urandom);
         reg_rd_addr_a_i = 2'($urandom);
         reg_rd_addr_b_i = 2'($urandom);
         reg_wr_addr_i = 2'($urandom);
         reg_wr_en_i = 1'($urandom);
         qhv_mux_i = 3'($urandom);
         qhv_wen_i = 1'($urandom);
         qhv_clr_i = ($urandom_range(0, 31) == 0);
         qhv_ready_i = 1'($urandom);
         step();
      end
      idle();

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
